// File: rtl/pixel_bram_arbiter.sv
// Round-robin arbiter sharing one pixel BRAM read port between NUM_CH LED channels.
// One read is in flight at a time; the word returns to the granted channel with an rvalid strobe.
module pixel_bram_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic                         bram_en,
  input  logic [DATA_WIDTH-1:0]        bram_dout,
  output logic [3:0]                   bram_web,
  output logic                         bram_rst
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(READ_LATENCY);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CH_W-1:0]       r_last;
  logic [CH_W-1:0]       r_owner;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_CH-1:0]     r_gnt;
  logic [NUM_CH-1:0]     r_rvalid;
  logic                  r_bram_en;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_found;
  logic [CH_W-1:0]       w_winner;
  logic                  w_issue;
  logic                  w_capture;
  logic [NUM_CH-1:0]     w_win_onehot;
  logic [NUM_CH-1:0]     w_owner_onehot;
  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_addr_split
    assign w_addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Search starts one past the last winner, so the previous winner is tried last.
  always_comb begin : rr_search
    int idx;
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(r_last) + k) % NUM_CH;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = CH_W'(idx);
      end
    end
  end

  assign w_win_onehot   = ONE_HOT0 << w_winner;
  assign w_owner_onehot = ONE_HOT0 << r_owner;

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_WAIT;
          w_issue     = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_DONE) begin
          w_state_nxt = S_IDLE;
          w_capture   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (!aresetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state     <= S_IDLE;
      r_last      <= LAST_CH;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_rdata     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= '0;
      r_rvalid  <= '0;
      r_bram_en <= 1'b0;
      if (w_issue) begin
        r_bram_addr <= w_addr_arr[w_winner];
        r_bram_en   <= 1'b1;
        r_gnt       <= w_win_onehot;
        r_owner     <= w_winner;
        r_last      <= w_winner;
        r_cnt       <= CNT_W'(1);
      end else if (r_state == S_WAIT && !w_capture) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // rdata is only overwritten on capture, so it holds between reads.
      if (w_capture) begin
        r_rdata  <= bram_dout;
        r_rvalid <= w_owner_onehot;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign bram_addr = r_bram_addr;
  assign bram_en   = r_bram_en;
  assign bram_web  = 4'b0000;
  assign bram_rst  = 1'b0;

endmodule

// File: tb/tb_pixel_bram_arbiter.sv
// Bench for pixel_bram_arbiter: a READ_LATENCY=2 and a READ_LATENCY=1 instance checked
// every cycle against a transaction-timeline model, plus directed scenario checks.
module tb_pixel_bram_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;

  logic [N-1:0]    req0, gnt0, rvalid0;
  logic [N*AW-1:0] addr0;
  logic [DW-1:0]   rdata0, dout0;
  logic [AW-1:0]   baddr0;
  logic            en0, brst0;
  logic [3:0]      web0;

  logic [N-1:0]    req1, gnt1, rvalid1;
  logic [N*AW-1:0] addr1;
  logic [DW-1:0]   rdata1, dout1;
  logic [AW-1:0]   baddr1;
  logic            en1, brst1;
  logic [3:0]      web1;

  pixel_bram_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut0 (
    .clk(clk), .aresetn(aresetn), .req(req0), .req_addr(addr0), .gnt(gnt0),
    .rvalid(rvalid0), .rdata(rdata0), .bram_addr(baddr0), .bram_en(en0),
    .bram_dout(dout0), .bram_web(web0), .bram_rst(brst0));

  pixel_bram_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .aresetn(aresetn), .req(req1), .req_addr(addr1), .gnt(gnt1),
    .rvalid(rvalid1), .rdata(rdata1), .bram_addr(baddr1), .bram_en(en1),
    .bram_dout(dout1), .bram_web(web1), .bram_rst(brst1));

  // BRAM contents are a fixed function of address; outside a valid read window dout is junk.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  logic [DW-1:0] pipe0;
  always @(posedge clk) pipe0 <= en0 ? mem_word(baddr0) : 32'hDEAD_BEEF;
  assign dout0 = pipe0;
  assign dout1 = en1 ? mem_word(baddr1) : 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timeline model: a grant at edge t blocks the port until t+RL, data returns at t+RL.
  int              m_rl [2] = '{2, 1};
  longint          m_free [2];
  int              m_last [2];
  bit              m_pend [2];
  longint          m_rv_cyc [2];
  int              m_rv_ch [2];
  logic [DW-1:0]   m_rv_data [2];
  logic [N-1:0]    e_gnt [2];
  logic [N-1:0]    e_rv [2];
  logic            e_en [2];
  logic [AW-1:0]   e_addr [2];
  logic [DW-1:0]   e_rdata [2];
  longint          cyc = 0;

  task automatic model(input int i, input logic [N-1:0] r, input logic [N*AW-1:0] a);
    int w;
    if (!aresetn) begin
      m_free[i] = cyc; m_last[i] = N - 1; m_pend[i] = 1'b0;
      e_gnt[i] = '0; e_rv[i] = '0; e_en[i] = 1'b0; e_addr[i] = '0; e_rdata[i] = '0;
    end else begin
      e_gnt[i] = '0; e_rv[i] = '0; e_en[i] = 1'b0;
      if (m_pend[i] && cyc == m_rv_cyc[i]) begin
        e_rv[i][m_rv_ch[i]] = 1'b1;
        e_rdata[i] = m_rv_data[i];
        m_pend[i] = 1'b0;
      end
      if (cyc >= m_free[i] && r != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && r[(m_last[i] + k) % N]) w = (m_last[i] + k) % N;
        end
        e_gnt[i][w] = 1'b1;
        e_en[i]     = 1'b1;
        e_addr[i]   = a[w*AW +: AW];
        m_last[i]   = w;
        m_pend[i]   = 1'b1;
        m_rv_cyc[i] = cyc + m_rl[i];
        m_rv_ch[i]  = w;
        m_rv_data[i] = mem_word(a[w*AW +: AW]);
        m_free[i]   = cyc + m_rl[i] + 1;
      end
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int            g_ch[$];
  longint        g_cyc[$];
  int            v_ch[$];
  longint        v_cyc[$];
  logic [DW-1:0] v_data[$];

  task automatic clear_logs();
    g_ch.delete(); g_cyc.delete(); v_ch.delete(); v_cyc.delete(); v_data.delete();
  endtask

  task automatic step();
    model(0, req0, addr0);
    model(1, req1, addr1);
    @(posedge clk);
    #1;
    check($sformatf("gnt0@%0d", cyc), gnt0, e_gnt[0]);
    check($sformatf("rvalid0@%0d", cyc), rvalid0, e_rv[0]);
    check($sformatf("rdata0@%0d", cyc), rdata0, e_rdata[0]);
    check($sformatf("en0@%0d", cyc), en0, e_en[0]);
    check($sformatf("baddr0@%0d", cyc), baddr0, e_addr[0]);
    check($sformatf("webrst0@%0d", cyc), {web0, brst0}, 5'b0);
    check($sformatf("gnt1@%0d", cyc), gnt1, e_gnt[1]);
    check($sformatf("rvalid1@%0d", cyc), rvalid1, e_rv[1]);
    check($sformatf("rdata1@%0d", cyc), rdata1, e_rdata[1]);
    check($sformatf("en1@%0d", cyc), en1, e_en[1]);
    check($sformatf("baddr1@%0d", cyc), baddr1, e_addr[1]);
    check($sformatf("webrst1@%0d", cyc), {web1, brst1}, 5'b0);
    if (gnt0 != '0) begin g_ch.push_back(oh_idx(gnt0)); g_cyc.push_back(cyc); end
    if (rvalid0 != '0) begin
      v_ch.push_back(oh_idx(rvalid0)); v_cyc.push_back(cyc); v_data.push_back(rdata0);
    end
    cyc++;
    // The latency-1 instance gets its own mostly-saturated random traffic throughout.
    req1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
    for (int c = 0; c < N; c++) addr1[c*AW +: AW] = $urandom;
  endtask

  task automatic reset_dut();
    aresetn = 1'b0;
    req0 = '0;
    step();
    aresetn = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int cnt2;

  initial begin
    aresetn = 1'b0;
    req0 = '0; addr0 = '0; req1 = '0; addr1 = '0;
    step();
    step();
    aresetn = 1'b1;

    // Single request on channel 2 at address 0x10.
    clear_logs();
    for (int c = 0; c < N; c++) addr0[c*AW +: AW] = $urandom;
    addr0[2*AW +: AW] = 32'h10;
    req0 = 4'b0100;
    step();
    req0 = '0;
    repeat (5) step();
    check("single_gnt_count", g_ch.size(), 1);
    check("single_rv_count", v_ch.size(), 1);
    if (g_ch.size() > 0 && v_ch.size() > 0) begin
      check("single_gnt_ch", g_ch[0], 2);
      check("single_rv_ch", v_ch[0], 2);
      check("single_rdata", v_data[0], 32'hA500_0010);
      check("single_latency", v_cyc[0] - g_cyc[0], 2);
    end

    // All four channels request continuously from reset.
    reset_dut();
    clear_logs();
    for (int c = 0; c < N; c++) addr0[c*AW +: AW] = 32'h100 + c;
    req0 = 4'b1111;
    repeat (13) step();
    check("all4_gnt_count", g_ch.size(), 5);
    if (g_ch.size() >= 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("all4_order%0d", k), g_ch[k], exp_order[k]);
      for (int k = 1; k < 5; k++) check($sformatf("all4_gap%0d", k), g_cyc[k] - g_cyc[k-1], 3);
    end

    // Channel 1 holds req; channel 3 re-requests in each of its rvalid cycles.
    reset_dut();
    clear_logs();
    req0 = 4'b1010;
    repeat (24) begin
      step();
      if (gnt0[3]) req0[3] = 1'b0;
      if (rvalid0[3]) req0[3] = 1'b1;
    end
    check("alt_gnt_count_ge6", g_ch.size() >= 6, 1);
    if (g_ch.size() >= 6) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("alt_order%0d", k), g_ch[k], (k % 2 == 0) ? 1 : 3);
    end

    // Channel 2 pulses req for one cycle while channel 0 is being served.
    reset_dut();
    clear_logs();
    req0 = 4'b0001;
    step();
    req0 = 4'b0100;
    step();
    req0 = 4'b0000;
    repeat (4) step();
    cnt2 = 0;
    foreach (g_ch[k]) if (g_ch[k] == 2) cnt2++;
    foreach (v_ch[k]) if (v_ch[k] == 2) cnt2++;
    check("withdraw_no_ch2", cnt2, 0);
    check("withdraw_gnt_count", g_ch.size(), 1);

    // Reset during WAIT discards the read and restores channel 0 priority.
    reset_dut();
    req0 = 4'b0010;
    step();
    check("midwait_gnt1", gnt0, 4'b0010);
    aresetn = 1'b0;
    req0 = '0;
    step();
    check("midwait_zero", {gnt0, rvalid0, en0, baddr0, rdata0}, '0);
    aresetn = 1'b1;
    clear_logs();
    repeat (3) step();
    check("midwait_no_rvalid", v_ch.size(), 0);
    req0 = 4'b1111;
    step();
    check("midwait_regrant0", gnt0, 4'b0001);
    req0 = '0;
    repeat (3) step();

    // Random traffic with occasional resets on both instances.
    for (int n = 0; n < 2000; n++) begin
      aresetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 1) == 0) req0 = 4'($urandom);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 1) == 0) addr0[c*AW +: AW] = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_bram_arbiter.md
# pixel_bram_arbiter

Round-robin arbiter that lets NUM_CH LED channel sequencers share one pixel BRAM read port. Each channel requests a word by address; the arbiter issues one BRAM read at a time, waits the fixed BRAM read latency and returns the word to the granted channel with a one-cycle valid strobe. It sits between the per-strip LED controllers and the single BRAM port, and drives that port's addr/en/web/rst pins.

## Interface
- NUM_CH, 4: number of requesting channels (2..16)
- ADDR_WIDTH, 32: BRAM address width
- DATA_WIDTH, 32: BRAM data width
- READ_LATENCY, 2: number of rising edges from the edge that asserts bram_en to the edge that samples bram_dout (>=1)

Ports:
- clk  in  1  single clock; every register updates on the rising edge
- aresetn  in  1  synchronous, active-low reset
- req  in  NUM_CH  per-channel read request, level
- req_addr  in  NUM_CH*ADDR_WIDTH  per-channel address; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_CH  one-hot, one-cycle pulse: request accepted
- rvalid  out  NUM_CH  one-hot, one-cycle pulse: rdata is valid for that channel
- rdata  out  DATA_WIDTH  returned word, shared by all channels
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_en  out  1  BRAM enable, one-cycle pulse per read
- bram_dout  in  DATA_WIDTH  BRAM read data
- bram_web  out  4  BRAM write enables, constant 0
- bram_rst  out  1  BRAM output reset, constant 0

## Operation
- States: IDLE, WAIT.
- IDLE: if no req bit is set, stay in IDLE. Otherwise pick a winner w by round-robin, searching from (last+1) mod NUM_CH upward with wrap-around. On that edge the arbiter:
  - sets bram_addr to the req_addr slice of w, unmodified
  - sets bram_en to 1 and gnt to onehot(w)
  - sets owner and last to w, cnt to 1
  - moves to WAIT
- WAIT:
  - bram_en and gnt go to 0.
  - If cnt == READ_LATENCY: set rdata to bram_dout, set rvalid to onehot(owner), go to IDLE.
  - Otherwise cnt increments.
  - req is ignored while in WAIT.
- rvalid is cleared on the edge after it is set. rdata holds its value until the next capture.
- Only one transaction is ever outstanding.
- Requester rules:
  - Hold req and req_addr stable until gnt is seen.
  - Drop req in the gnt cycle unless another read is wanted.
  - Deasserting req before gnt withdraws the request; the arbiter never grants a channel whose req is low at the sampling edge.
- Fairness: a channel that has just been granted has the lowest priority at the next arbitration. Any continuously asserted req is granted within NUM_CH arbitrations.
- Reset (aresetn low at an edge, including mid-WAIT):
  - state to IDLE, last to NUM_CH-1, so channel 0 has first priority
  - owner, cnt, gnt, rvalid, bram_en, bram_addr and rdata to 0
  - any in-flight read is discarded and no rvalid is produced for it
- bram_web and bram_rst are 0 at all times, including during reset.

## Timing
- Edge E0 (in IDLE with req set): gnt, bram_en and bram_addr are high/valid for cycle E0..E0+1.
- Edge E0+READ_LATENCY: bram_dout is captured. rdata and rvalid are valid for the cycle that follows.
- The arbiter is in IDLE during the rvalid cycle, so it can issue the next grant at edge E0+READ_LATENCY+1.
- Throughput: one read per READ_LATENCY+1 cycles, which is 3 cycles at the default.
- Latency from gnt to rvalid: READ_LATENCY cycles.
- A req asserted in the rvalid cycle is eligible at the next edge. A channel can therefore re-request without losing its place, but round-robin still applies.

## Test plan
- Single request: req=4'b0100, addr2=0x10, BRAM model returns 0xA5000010 for address 0x10 -> gnt=4'b0100 for 1 cycle with bram_addr=0x10 and bram_en=1; 2 cycles later rvalid=4'b0100 and rdata=0xA5000010; no other pulses.
- All four channels request continuously from reset -> grants in order 0,1,2,3,0, one every 3 cycles; each rvalid matches its grant's owner and address.
- Channel 1 holds req permanently, channel 3 re-requests in each of its rvalid cycles -> grants alternate 1,3,1,3; neither channel is starved.
- Channel 2 raises req and drops it one cycle later while the arbiter is in WAIT serving channel 0 -> channel 2 is never granted and no spurious gnt or rvalid appears for it.
- aresetn pulled low for 1 cycle during WAIT (cnt=1) -> no rvalid for that read; all outputs are 0; the next arbitration with req=4'b1111 grants channel 0.
- READ_LATENCY=1 build: grant at edge E0 -> rvalid in the cycle after E0+1, with back-to-back grants every 2 cycles.
